adder_tree_acc: RTL and testbench

ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

---
 rtl/adder_tree_acc.sv | 175 +++++++++++++++++
 tb/tb_adder_tree_acc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: multi-lane reduction engine.
// Each accepted beat carries NUM_IN unsigned lanes. The lanes are summed by a
// pipelined binary adder tree of log2(NUM_IN) register stages. Every tree
// output is then added into a wrapping accumulator. The run length in beats
// is given with start.
// Optional feature: define ADDER_TREE_ACC_OVF_EN to add a sticky 'ovf' output
// that records a carry out of the accumulator since the last accepted start.
//
// din handshake: a beat transfers on a rising clk edge where din_valid and
// din_ready are both high. din_ready is high only in LOAD and does not depend
// on din_valid. The source may insert gaps; a gap only stalls the beat count.
module adder_tree_acc #(
   parameter int NUM_IN = 8,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 8,
   parameter int ACC_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         len,
   output logic                     busy,
   input  logic                     din_valid,
   output logic                     din_ready,
   input  logic [NUM_IN*DATA_W-1:0] din,
   output logic                     done,
   output logic [ACC_W-1:0]         dout,
`ifdef ADDER_TREE_ACC_OVF_EN
   output logic                     ovf,
`endif
   output logic [1:0]               state_o
);

   localparam int L  = $clog2(NUM_IN);
   localparam int TW = DATA_W + L;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             accept;
   logic             last_tok;
   logic [L:0]       tok_vec;
   logic [TW-1:0]    tree_out;
   logic [ACC_W-1:0] tree_ext;

   assign accept = din_valid && (state_q == LOAD);

   // Tree levels: level 0 is the raw input, level k holds NUM_IN>>k sums
   // of DATA_W+k bits. Each pair is zero-extended by one bit before adding,
   // so no level can truncate.
   for (genvar k = 0; k <= L; k++) begin : g_lvl
      localparam int W = DATA_W + k;
      localparam int N = NUM_IN >> k;
      logic [N*W-1:0] node;
      logic           tok;

      if (k == 0) begin : g_in
         assign node = din;
         assign tok  = accept;
      end else begin : g_add
         logic [N*W-1:0] node_d;
         for (genvar j = 0; j < N; j++) begin : g_pair
            assign node_d[j*W +: W] =
               {1'b0, g_lvl[k-1].node[(2*j)*(W-1) +: W-1]} +
               {1'b0, g_lvl[k-1].node[(2*j+1)*(W-1) +: W-1]};
         end
         // Register one tree level together with its valid token.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               node <= '0;
               tok  <= 1'b0;
            end else begin
               node <= node_d;
               tok  <= g_lvl[k-1].tok;
            end
         end
      end

      assign tok_vec[k] = tok;
   end

   assign tree_out = g_lvl[L].node;
   assign tree_ext = ACC_W'(tree_out);

   // In DRAIN no new tokens enter, so the token at the tree output is the
   // last one once every earlier level is empty.
   assign last_tok = tok_vec[L] && !(|tok_vec[L-1:0]);

`ifdef ADDER_TREE_ACC_OVF_EN
   logic [ACC_W:0] acc_sum;
   logic           ovf_q, ovf_d;
   assign acc_sum = {1'b0, acc_q} + {1'b0, tree_ext};
`else
   logic [ACC_W-1:0] acc_sum;
   assign acc_sum = acc_q + tree_ext;
`endif

   // Next-state logic: FSM, beat countdown and accumulator update.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
`ifdef ADDER_TREE_ACC_OVF_EN
      ovf_d   = ovf_q;
      if (tok_vec[L] && acc_sum[ACC_W]) ovf_d = 1'b1;
`endif
      if (tok_vec[L]) acc_d = acc_sum[ACC_W-1:0];

      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d = '0;
`ifdef ADDER_TREE_ACC_OVF_EN
               ovf_d = 1'b0;
`endif
               if (len == '0) begin
                  state_d = DONE;
               end else begin
                  rem_d   = len;
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (accept) begin
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_tok) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and accumulator registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         acc_q   <= '0;
`ifdef ADDER_TREE_ACC_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
`ifdef ADDER_TREE_ACC_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy      = (state_q != IDLE);
   assign din_ready = (state_q == LOAD);
   assign done      = (state_q == DONE);
   assign dout      = acc_q;
   assign state_o   = state_q;
`ifdef ADDER_TREE_ACC_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc (NUM_IN=8, DATA_W=16).
// Default build uses ACC_W=32. With ADDER_TREE_ACC_OVF_EN it uses ACC_W=20
// and also checks the ovf flag.
module tb_adder_tree_acc;
  localparam int NUM_IN = 8;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;
`ifdef ADDER_TREE_ACC_OVF_EN
  localparam int ACC_W  = 20;
  localparam logic [ACC_W-1:0] EXP_FULL3 = 524264;
`else
  localparam int ACC_W  = 32;
  localparam logic [ACC_W-1:0] EXP_FULL3 = 1572840;
`endif
  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                     start = 1'b0;
  logic [LEN_W-1:0]         len = '0;
  logic                     busy;
  logic                     din_valid = 1'b0;
  logic                     din_ready;
  logic [NUM_IN*DATA_W-1:0] din = '0;
  logic                     done;
  logic [ACC_W-1:0]         dout;
  logic [1:0]               state_o;
`ifdef ADDER_TREE_ACC_OVF_EN
  logic                     ovf;
`endif

  adder_tree_acc #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .done(done), .dout(dout),
`ifdef ADDER_TREE_ACC_OVF_EN
    .ovf(ovf),
`endif
    .state_o(state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int rdy_cnt  = 0;
  logic [ACC_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (din_ready) rdy_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = $urandom_range(255, 0);
  endtask

  task automatic feed(input logic [NUM_IN*DATA_W-1:0] data, input logic [15:0] vpat,
                      input int n, output int hs);
    hs = 0;
    for (int i = 0; i < n; i++) begin
      din       = data;
      din_valid = vpat[i];
      if (din_valid && din_ready) hs++;
      tick();
    end
    din_valid = 1'b0;
    din       = '0;
  endtask

  // Called in the cycle right after the last handshake (cycle c+1).
  task automatic wait_done(input string tag);
    int lat;
    logic [ACC_W-1:0] e;
    lat = 1;
    while (!done && lat < 50) begin
      tick();
      lat++;
    end
    e = exp_q.pop_front();
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_dout"}, dout, e);
  endtask

  function automatic logic [NUM_IN*DATA_W-1:0] lanes(input int base, input int step);
    logic [NUM_IN*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_IN; i++) v[i*DATA_W +: DATA_W] = DATA_W'(base + step*i);
    return v;
  endfunction

  // ---------------- directed steps ----------------
  initial begin
    int hs;
    int d0;
    int r0;

    // reset state
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_din_ready", din_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dout", dout, '0);
    chk("rst_state", state_o, 2'd0);
    tick();
    rst = 1'b0;
    tick();

    // single beat, lanes 1..8 -> 36
    exp_q.push_back(36);
    do_start(1);
    chk("t1_ready", din_ready, 1'b1);
    chk("t1_busy", busy, 1'b1);
    feed(lanes(1, 1), 16'h0001, 1, hs);
    chk("t1_hs", hs, 1);
    chk("t1_drain_ready", din_ready, 1'b0);
    wait_done("t1");
`ifdef ADDER_TREE_ACC_OVF_EN
    chk("t1_ovf", ovf, 1'b0);
`endif
    tick();
    chk("t1_busy_after", busy, 1'b0);
    chk("t1_done_after", done, 1'b0);
    chk("t1_dout_hold", dout, 36);

    // len=3, lanes 0xFFFF, valid 1,0,1,0,1
    exp_q.push_back(EXP_FULL3);
    d0 = done_cnt;
    do_start(3);
    feed(lanes(16'hFFFF, 0), 16'b10101, 5, hs);
    chk("t2_hs", hs, 3);
    wait_done("t2");
`ifdef ADDER_TREE_ACC_OVF_EN
    chk("t2_ovf", ovf, 1'b1);
`endif
    tick();
    tick();
    chk("t2_done_pulses", done_cnt - d0, 1);

    // len=0 -> done next cycle, dout 0, no ready
    r0 = rdy_cnt;
    do_start(0);
    chk("t3_done", done, 1'b1);
    chk("t3_dout", dout, '0);
    chk("t3_ready", din_ready, 1'b0);
`ifdef ADDER_TREE_ACC_OVF_EN
    chk("t3_ovf_cleared", ovf, 1'b0);
`endif
    tick();
    chk("t3_idle", state_o, 2'd0);
    tick();
    chk("t3_ready_never", rdy_cnt - r0, 0);

    // reset after 2nd of 4 beats (lanes 10 -> 80 per beat)
    do_start(4);
    feed(lanes(10, 0), 16'b11, 2, hs);
    tick();
    tick();
    tick();
    chk("t4_partial", dout, 160);
    chk("t4_still_load", din_ready, 1'b1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("t4_rst_busy", busy, 1'b0);
    chk("t4_rst_dout", dout, '0);
    chk("t4_rst_ready", din_ready, 1'b0);
    chk("t4_rst_done", done, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_idle", state_o, 2'd0);
    exp_q.push_back(3600);
    do_start(1);
    feed(lanes(100, 100), 16'b1, 1, hs);
    wait_done("t4b");

    // start held high through a run
    tick();
    exp_q.push_back(16);
    start = 1'b1;
    len   = 2;
    tick();
    chk("t5_load", state_o, 2'd1);
    feed(lanes(1, 0), 16'b11, 2, hs);
    wait_done("t5a");
    tick();
    chk("t5_idle_after_done", state_o, 2'd0);
    chk("t5_busy_idle", busy, 1'b0);
    chk("t5_dout_hold", dout, 16);
    tick();
    chk("t5_restart", state_o, 2'd1);
    chk("t5_cleared", dout, '0);
    start = 1'b0;
    exp_q.push_back(88);
    feed(lanes(2, 1), 16'b11, 2, hs);
    wait_done("t5b");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Overall time bound so the bench always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
